instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Parametrised instruction fetch unit that replaces the single-word, one-PC-per-request fetch path. It autonomously generates sequential PCs, reads a synchronous instruction memory with 1-cycle read latency, and buffers fetched words in a DEPTH-entry queue. Words are presented to decode through a valid/ready handshake. A redirect input flushes the queue and restarts fetch at a new PC for branches and jumps. It sits between the instruction memory and the decode stage.

## Interface
- ADDR_W, 32, PC/address width
- DATA_W, 32, instruction width
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 0, first fetch address after reset
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_en  out  1  read request to instruction memory this cycle
- mem_addr  out  ADDR_W  read address; always equals fetch_pc
- mem_data  in  DATA_W  read data; valid the cycle after mem_en=1
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  ADDR_W  new fetch PC; bits [1:0] forced to 0
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_instr  out  DATA_W  head instruction; 0 when out_valid=0
- out_pc  out  ADDR_W  PC of head instruction; 0 when out_valid=0

## Operation
- State: fetch_pc, inflight bit (request issued last cycle), queue with count 0..DEPTH.
- Reset values: fetch_pc=RESET_PC, count=0, inflight=0, mem_en=0, out_valid=0, out_instr=0, out_pc=0.
- pop = out_valid & out_ready.
- Issue condition: !redirect_valid and (count+inflight < DEPTH, or count+inflight == DEPTH and pop).
  - On issue: mem_en=1, mem_addr=fetch_pc, then fetch_pc += 4, modulo 2^ADDR_W with silent wrap.
  - Invariant: count+inflight ≤ DEPTH, so a returning word never overflows the queue.
- Return: if inflight and !redirect_valid, push {fetch address, mem_data} at the clock edge.
- Simultaneous push and pop on a full queue is legal; count is unchanged.
- Redirect in cycle R:
  - no issue in R;
  - queue cleared at the end of R;
  - the word returning in R is dropped;
  - fetch_pc ← {redirect_pc[ADDR_W-1:2],2'b00};
  - a pop handshake in R still counts as delivered to decode.
- Back-to-back redirects: each stalls issue; the last one wins.
- Reset asserted mid-operation: all state clears immediately (asynchronous); in-flight data is discarded.

## Timing
- Cycle 0 is the first cycle with rst_n high: mem_en=1, mem_addr=RESET_PC.
- mem_data arrives in cycle 1 and is pushed at the end of cycle 1; out_valid=1 in cycle 2.
- Issue-to-out_valid latency is 2 cycles.
- Steady-state throughput is 1 instruction/cycle with out_ready held high.
- Redirect in R: mem_en=0 in R; mem_en=1 with addr=redirect_pc in R+1; out_valid=0 in R+1 and R+2; out_valid=1 with out_pc=redirect_pc in R+3.
- Backpressure: with out_ready=0, issue stops once count+inflight=DEPTH. When out_ready rises, issue resumes in the same cycle as the first pop.
- out_valid, out_instr and out_pc are driven only from registers (queue head), never combinationally from mem_data.

## Structure
- Shared package constants: PC_STEP=4 and the instruction-word width default. These are shared with decode and the branch unit.
- Sub-module: ifq_fifo.
  - Synchronous FIFO, DEPTH × (ADDR_W+DATA_W).
  - Ports: push, pop, flush, count.
  - flush has priority over push in the same cycle.
- Top level holds fetch_pc, inflight and the issue/redirect logic.

## Test plan
Bench memory model: mem_data = addr ^ 32'hA5A5_0000, registered one cycle.
- Reset release, out_ready=1 → out_pc sequence 0,4,8,… from cycle 2, one per cycle, out_instr=pc^A5A50000.
- out_ready=0 for 10 cycles, DEPTH=4 → exactly 4 issues, count=4, mem_en=0 afterwards; release → pcs 0,4,8,12,16 in order, with no gap and no duplicate.
- Redirect to 0x100 while 3 entries are queued and one word is in flight → no pre-redirect PC ever appears after R; out_pc=0x100 at R+3, then 0x104.
- redirect_pc=0x203 → first fetched out_pc=0x200.
- Redirect on two consecutive cycles (0x40, then 0x80) → first output out_pc=0x80.
- RESET_PC=32'hFFFF_FFF8 → out_pc sequence FFFF_FFF8, FFFF_FFFC, 0, 4; rst_n pulsed low mid-stream → out_valid=0 immediately, restart at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_queue_pkg.sv
// Constants shared by the fetch queue, the decode stage and the branch unit.
package instr_fetch_queue_pkg;

  localparam int PC_STEP = 4;
  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus: instruction-memory read port, redirect input and decode handshake.
interface instr_fetch_queue_if
  import instr_fetch_queue_pkg::*;
#(
  parameter int ADDR_W = PC_W,
  parameter int DATA_W = INSTR_W
);

  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;

  // master is the fetch unit; slave is the memory/decode/branch environment
  modport master (
    output mem_en, mem_addr, out_valid, out_instr, out_pc,
    input  mem_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  mem_en, mem_addr, out_valid, out_instr, out_pc,
    output mem_data, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/instr_fetch_queue_ifq_fifo.sv
// Synchronous FIFO holding {pc, instruction} entries; flush beats push in the same cycle.
module ifq_fifo
  import instr_fetch_queue_pkg::*;
#(
  parameter int WIDTH = PC_W + INSTR_W,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPop;

  assign w_doPop = i_pop && (r_count != '0);

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_doPop) r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({i_push, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wrPtr] <= i_data;
  end

  assign o_data  = r_mem[r_rdPtr];
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_queue.sv
// Autonomous sequential fetch with a DEPTH-entry buffer toward decode and redirect-driven flush.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int                ADDR_W   = PC_W,
  parameter int                DATA_W   = INSTR_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_queue_if.master bus
);

  localparam int              CNT_W   = $clog2(DEPTH + 1);
  localparam int              ENTRY_W = ADDR_W + DATA_W;
  localparam logic [CNT_W:0]  DEPTH_V = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0]  r_fetchPc;
  logic [ADDR_W-1:0]  r_inflightPc;
  logic               r_inflight;

  logic [CNT_W-1:0]   w_count;
  logic [ENTRY_W-1:0] w_head;
  logic               w_outValid;
  logic               w_pop;
  logic               w_issue;
  logic               w_push;
  logic [CNT_W:0]     w_pending;
  logic [ADDR_W-1:0]  w_redirectPc;

  // Queue slots are reserved at issue time so a returning word always has room
  always_comb begin
    w_outValid   = (w_count != '0);
    w_pop        = w_outValid && bus.out_ready;
    w_pending    = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
    w_issue      = rst_n && !bus.redirect_valid &&
                   ((w_pending < DEPTH_V) || ((w_pending == DEPTH_V) && w_pop));
    w_push       = r_inflight && !bus.redirect_valid;
    w_redirectPc = bus.redirect_pc & {{(ADDR_W-2){1'b1}}, 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetchPc    <= RESET_PC;
      r_inflightPc <= '0;
      r_inflight   <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_fetchPc  <= w_redirectPc;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflightPc <= r_fetchPc;
        r_fetchPc    <= r_fetchPc + ADDR_W'(PC_STEP);
      end
    end
  end

  ifq_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.redirect_valid),
    .i_data  ({r_inflightPc, bus.mem_data}),
    .o_data  (w_head),
    .o_count (w_count)
  );

  assign bus.mem_en    = w_issue;
  assign bus.mem_addr  = r_fetchPc;
  assign bus.out_valid = w_outValid;
  assign bus.out_instr = w_outValid ? w_head[DATA_W-1:0] : '0;
  assign bus.out_pc    = w_outValid ? w_head[ENTRY_W-1:DATA_W] : '0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench: per-cycle vector table, redirect sequences and a delivery scoreboard.
module tb_instr_fetch_queue;
  import instr_fetch_queue_pkg::*;

  localparam int          ADDR_W  = 32;
  localparam int          DATA_W  = 32;
  localparam int          DEPTH   = 4;
  localparam logic [31:0] MEM_XOR = 32'hA5A5_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  typedef struct {
    logic        outReady;
    logic        expMemEn;
    logic [31:0] expMemAddr;
    logic        expOutValid;
    logic [31:0] expOutPc;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rst1_n = 1'b0;
  int   compared   = 0;
  int   mismatched = 0;
  logic [31:0] expQ [$];
  vec_t vecs [15];

  instr_fetch_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();
  instr_fetch_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

  instr_fetch_queue #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(32'h0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  instr_fetch_queue #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(WRAP_PC)
  ) dut1 (
    .clk(clk), .rst_n(rst1_n), .bus(bus1)
  );

  always #5 clk = ~clk;

  // Instruction memory model: one-cycle registered read, data = addr ^ A5A50000
  always @(posedge clk) begin
    if (bus0.mem_en) bus0.mem_data <= bus0.mem_addr ^ MEM_XOR;
    if (bus1.mem_en) bus1.mem_data <= bus1.mem_addr ^ MEM_XOR;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    bus0.out_ready      = ready;
    bus0.redirect_valid = rv;
    bus0.redirect_pc    = rpc;
  endtask

  task automatic checkCycle(input string name, input logic expEn, input logic [31:0] expAddr,
                            input logic expValid, input logic [31:0] expPc);
    @(negedge clk);
    checkOutput({name, "_memEn"}, 32'(bus0.mem_en), 32'(expEn));
    checkOutput({name, "_memAddr"}, bus0.mem_addr, expAddr);
    checkOutput({name, "_outValid"}, 32'(bus0.out_valid), 32'(expValid));
    checkOutput({name, "_outPc"}, bus0.out_pc, expPc);
    checkOutput({name, "_outInstr"}, bus0.out_instr, expValid ? (expPc ^ MEM_XOR) : 32'h0);
  endtask

  task automatic checkDut1(input string name, input logic expValid, input logic [31:0] expPc);
    @(negedge clk);
    checkOutput({name, "_outValid"}, 32'(bus1.out_valid), 32'(expValid));
    checkOutput({name, "_outPc"}, bus1.out_pc, expPc);
    checkOutput({name, "_outInstr"}, bus1.out_instr, expValid ? (expPc ^ MEM_XOR) : 32'h0);
  endtask

  task automatic resetDut(input bit checkDrain);
    @(posedge clk);
    #1;
    if (checkDrain) checkOutput("drainAll", 32'(expQ.size()), 32'h0);
    rst_n = 1'b0;
    bus0.out_ready      = 1'b0;
    bus0.redirect_valid = 1'b0;
    bus0.redirect_pc    = 32'h0;
    #1;
    checkOutput("rstOutValid", 32'(bus0.out_valid), 32'h0);
    checkOutput("rstMemEn", 32'(bus0.mem_en), 32'h0);
    expQ.delete();
    repeat (2) @(posedge clk);
  endtask

  task automatic releaseDut(input logic ready);
    @(posedge clk);
    #1;
    rst_n          = 1'b1;
    bus0.out_ready = ready;
  endtask

  // Every handshake on dut0 must deliver the next PC the scoreboard expects
  always @(negedge clk) begin
    if (rst_n && bus0.out_valid && bus0.out_ready) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpectedPop: actual=%h required=none", bus0.out_pc);
      end else begin
        logic [31:0] expPc;
        expPc = expQ.pop_front();
        checkOutput("popPc", bus0.out_pc, expPc);
        checkOutput("popInstr", bus0.out_instr, expPc ^ MEM_XOR);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs = '{
      '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00},
      '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00},
      '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00},
      '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h00},
      '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00},
      '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00},
      '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00},
      '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00},
      '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00},
      '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00},
      '{1'b1, 1'b1, 32'h10, 1'b1, 32'h00},
      '{1'b1, 1'b1, 32'h14, 1'b1, 32'h04},
      '{1'b1, 1'b1, 32'h18, 1'b1, 32'h08},
      '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h0C},
      '{1'b1, 1'b1, 32'h20, 1'b1, 32'h10}
    };

    bus0.out_ready = 1'b0; bus0.redirect_valid = 1'b0; bus0.redirect_pc = 32'h0;
    bus1.out_ready = 1'b0; bus1.redirect_valid = 1'b0; bus1.redirect_pc = 32'h0;

    #2;
    checkOutput("resetMemEn", 32'(bus0.mem_en), 32'h0);
    checkOutput("resetOutValid", 32'(bus0.out_valid), 32'h0);
    checkOutput("resetOutInstr", bus0.out_instr, 32'h0);
    checkOutput("resetOutPc", bus0.out_pc, 32'h0);
    repeat (2) @(posedge clk);

    // Streaming with out_ready held high
    for (int i = 0; i < 10; i++) expQ.push_back(32'(4 * i));
    releaseDut(1'b1);
    checkCycle("stream0", 1'b1, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkCycle("stream1", 1'b1, 32'h4, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkCycle("stream2", 1'b1, 32'h8, 1'b1, 32'h0);
    for (int c = 3; c < 12; c++) applyStimulus(1'b1, 1'b0, 32'h0);
    resetDut(1'b1);

    // Backpressure table
    for (int i = 0; i < 5; i++) expQ.push_back(32'(4 * i));
    for (int k = 0; k < 15; k++) begin
      if (k == 0) releaseDut(vecs[k].outReady);
      else applyStimulus(vecs[k].outReady, 1'b0, 32'h0);
      checkCycle($sformatf("bp%0d", k), vecs[k].expMemEn, vecs[k].expMemAddr,
                 vecs[k].expOutValid, vecs[k].expOutPc);
    end
    resetDut(1'b1);

    // Redirect with 3 queued + 1 in flight, pop in the redirect cycle
    expQ.push_back(32'h0);
    for (int i = 0; i < 4; i++) expQ.push_back(32'h100 + 32'(4 * i));
    releaseDut(1'b0);
    for (int c = 1; c < 4; c++) applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h100);
    checkCycle("redirR", 1'b0, 32'h10, 1'b1, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkCycle("redirR1", 1'b1, 32'h100, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkCycle("redirR2", 1'b1, 32'h104, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkCycle("redirR3", 1'b1, 32'h108, 1'b1, 32'h100);
    for (int c = 0; c < 3; c++) applyStimulus(1'b1, 1'b0, 32'h0);
    resetDut(1'b1);

    // Misaligned redirect target
    expQ.push_back(32'h0); expQ.push_back(32'h4);
    expQ.push_back(32'h200); expQ.push_back(32'h204);
    releaseDut(1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h203);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkCycle("alignR1", 1'b1, 32'h200, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkCycle("alignR2", 1'b1, 32'h204, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkCycle("alignR3", 1'b1, 32'h208, 1'b1, 32'h200);
    applyStimulus(1'b1, 1'b0, 32'h0);
    resetDut(1'b1);

    // Back-to-back redirects: the later one wins
    expQ.push_back(32'h0); expQ.push_back(32'h4);
    expQ.push_back(32'h80); expQ.push_back(32'h84);
    releaseDut(1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h40);
    applyStimulus(1'b1, 1'b1, 32'h80);
    checkCycle("dblR", 1'b0, 32'h40, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkCycle("dblR1", 1'b1, 32'h80, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkCycle("dblR2", 1'b1, 32'h84, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkCycle("dblR3", 1'b1, 32'h88, 1'b1, 32'h80);
    applyStimulus(1'b1, 1'b0, 32'h0);
    resetDut(1'b1);

    // Address wrap from a high RESET_PC, then a mid-stream reset
    @(posedge clk);
    #1;
    rst1_n = 1'b1;
    bus1.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("wrap0_memEn", 32'(bus1.mem_en), 32'h1);
    checkOutput("wrap0_memAddr", bus1.mem_addr, WRAP_PC);
    checkDut1("wrap1", 1'b0, 32'h0);
    checkDut1("wrap2", 1'b1, 32'hFFFF_FFF8);
    checkDut1("wrap3", 1'b1, 32'hFFFF_FFFC);
    checkDut1("wrap4", 1'b1, 32'h0000_0000);
    checkDut1("wrap5", 1'b1, 32'h0000_0004);
    @(posedge clk);
    #1;
    rst1_n = 1'b0;
    #1;
    checkOutput("midRstOutValid", 32'(bus1.out_valid), 32'h0);
    checkOutput("midRstOutPc", bus1.out_pc, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst1_n = 1'b1;
    @(negedge clk);
    checkOutput("restart_memEn", 32'(bus1.mem_en), 32'h1);
    checkOutput("restart_memAddr", bus1.mem_addr, WRAP_PC);
    checkDut1("restart1", 1'b0, 32'h0);
    checkDut1("restart2", 1'b1, 32'hFFFF_FFF8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
